// File: rtl/poly_voice_allocator_if.sv
// Event and voice-control bundle between the note producer and the voice allocator.
// The producer drives the ev_* side; the allocator drives ev_ready and the voice_* side.
interface poly_voice_allocator_if #(
  parameter int NUM_VOICES = 4
);
  logic                  ev_valid;
  logic                  ev_ready;
  logic                  ev_on;
  logic [3:0]            ev_note;
  logic [2:0]            ev_octave;
  logic [NUM_VOICES-1:0] voice_ld;
  logic [3:0]            voice_note;
  logic [2:0]            voice_octave;
  logic [NUM_VOICES-1:0] voice_active;
  logic                  steal;

  modport master (
    output ev_valid, ev_on, ev_note, ev_octave,
    input  ev_ready, voice_ld, voice_note, voice_octave, voice_active, steal
  );

  modport slave (
    input  ev_valid, ev_on, ev_note, ev_octave,
    output ev_ready, voice_ld, voice_note, voice_octave, voice_active, steal
  );
endinterface

// File: rtl/poly_voice_allocator.sv
// Polyphonic note scheduler: maps note-on/off events onto voice datapaths with
// retrigger of held notes, lowest-free allocation and round-robin stealing when full.
module poly_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int PTR_W      = 2
) (
  input logic                clk,
  input logic                reset,
  poly_voice_allocator_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEARCH,
    S_COMMIT
  } state_e;

  state_e                state_q, state_d;
  logic                  on_q, on_d;
  logic [3:0]            note_q, note_d;
  logic [2:0]            oct_q, oct_d;
  logic [PTR_W-1:0]      target_q, target_d;
  logic                  stolen_q, stolen_d;
  logic                  hit_q, hit_d;
  logic [PTR_W-1:0]      steal_ptr_q, steal_ptr_d;
  logic [NUM_VOICES-1:0] active_q, active_d;
  logic [3:0]            tbl_note_q [NUM_VOICES];
  logic [3:0]            tbl_note_d [NUM_VOICES];
  logic [2:0]            tbl_oct_q  [NUM_VOICES];
  logic [2:0]            tbl_oct_d  [NUM_VOICES];
  logic [3:0]            vnote_q, vnote_d;
  logic [2:0]            voct_q, voct_d;

  logic                  match_found, free_found;
  logic [PTR_W-1:0]      match_idx, free_idx;

  // Scanning from the top down lets the lowest matching index overwrite the rest.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active_q[i] && tbl_note_q[i] == note_q && tbl_oct_q[i] == oct_q) begin
        match_found = 1'b1;
        match_idx   = PTR_W'(i);
      end
      if (!active_q[i]) begin
        free_found = 1'b1;
        free_idx   = PTR_W'(i);
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d     = state_q;
    on_d        = on_q;
    note_d      = note_q;
    oct_d       = oct_q;
    target_d    = target_q;
    stolen_d    = stolen_q;
    hit_d       = hit_q;
    steal_ptr_d = steal_ptr_q;
    active_d    = active_q;
    tbl_note_d  = tbl_note_q;
    tbl_oct_d   = tbl_oct_q;
    vnote_d     = vnote_q;
    voct_d      = voct_q;

    unique case (state_q)
      S_IDLE: begin
        // Out-of-range notes/octaves are consumed here without leaving IDLE.
        if (bus.ev_valid && bus.ev_note < 4'd12 && bus.ev_octave != 3'd7) begin
          on_d    = bus.ev_on;
          note_d  = bus.ev_note;
          oct_d   = bus.ev_octave;
          state_d = S_SEARCH;
        end
      end

      S_SEARCH: begin
        stolen_d = 1'b0;
        hit_d    = 1'b0;
        state_d  = S_COMMIT;
        if (on_q) begin
          hit_d = 1'b1;
          if (match_found) begin
            target_d = match_idx;
          end else if (free_found) begin
            target_d = free_idx;
          end else begin
            target_d    = steal_ptr_q;
            stolen_d    = 1'b1;
            steal_ptr_d = (steal_ptr_q == PTR_W'(NUM_VOICES - 1)) ? '0 : steal_ptr_q + 1'b1;
          end
          active_d[target_d]   = 1'b1;
          tbl_note_d[target_d] = note_q;
          tbl_oct_d[target_d]  = oct_q;
          vnote_d              = note_q;
          voct_d               = oct_q;
        end else if (match_found) begin
          hit_d               = 1'b1;
          target_d            = match_idx;
          active_d[match_idx] = 1'b0;
        end
      end

      S_COMMIT: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      on_q        <= 1'b0;
      note_q      <= '0;
      oct_q       <= '0;
      target_q    <= '0;
      stolen_q    <= 1'b0;
      hit_q       <= 1'b0;
      steal_ptr_q <= '0;
      active_q    <= '0;
      vnote_q     <= '0;
      voct_q      <= '0;
      // NOTE: the note table is small register state, so it is cleared explicitly rather than left as uninitialised memory.
      for (int i = 0; i < NUM_VOICES; i++) begin
        tbl_note_q[i] <= '0;
        tbl_oct_q[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q     <= state_d;
      on_q        <= on_d;
      note_q      <= note_d;
      oct_q       <= oct_d;
      target_q    <= target_d;
      stolen_q    <= stolen_d;
      hit_q       <= hit_d;
      steal_ptr_q <= steal_ptr_d;
      active_q    <= active_d;
      vnote_q     <= vnote_d;
      voct_q      <= voct_d;
      tbl_note_q  <= tbl_note_d;
      tbl_oct_q   <= tbl_oct_d;
    end
  end

  assign bus.ev_ready     = (state_q == S_IDLE) && reset;
  assign bus.voice_ld     = (state_q == S_COMMIT && on_q && hit_q) ?
                            (NUM_VOICES'(1) << target_q) : '0;
  assign bus.steal        = (state_q == S_COMMIT) && stolen_q;
  assign bus.voice_active = active_q;
  assign bus.voice_note   = vnote_q;
  assign bus.voice_octave = voct_q;

endmodule

// File: tb/tb_poly_voice_allocator.sv
// Randomised and directed bench for poly_voice_allocator against an array-based
// model of the voice table (match, lowest free, round-robin steal).
module tb_poly_voice_allocator;
  localparam int NV = 4;

  logic clk = 1'b0;
  logic reset;
  int   tests  = 0;
  int   failed = 0;

  poly_voice_allocator_if #(.NUM_VOICES(NV)) bus();

  poly_voice_allocator #(.NUM_VOICES(NV), .PTR_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: what each voice holds, plus the steal cursor.
  bit         m_act  [NV];
  logic [3:0] m_note [NV];
  logic [2:0] m_oct  [NV];
  int         m_ptr;
  logic [3:0] m_vnote;
  logic [2:0] m_voct;

  task automatic model_reset();
    for (int i = 0; i < NV; i++) begin
      m_act[i] = 0; m_note[i] = 0; m_oct[i] = 0;
    end
    m_ptr = 0; m_vnote = 0; m_voct = 0;
  endtask

  function automatic logic [NV-1:0] m_mask();
    logic [NV-1:0] m;
    m = '0;
    for (int i = 0; i < NV; i++) m[i] = m_act[i];
    return m;
  endfunction

  task automatic model_apply(input bit on, input logic [3:0] note, input logic [2:0] oct,
                             output bit valid_ev, output bit pulse, output bit stl,
                             output int tgt);
    int hit, fr;
    valid_ev = (note <= 11) && (oct <= 6);
    pulse = 0; stl = 0; tgt = -1;
    if (!valid_ev) return;
    hit = -1; fr = -1;
    for (int i = NV - 1; i >= 0; i--) begin
      if (m_act[i] && m_note[i] == note && m_oct[i] == oct) hit = i;
      if (!m_act[i]) fr = i;
    end
    if (on) begin
      if (hit >= 0) tgt = hit;
      else if (fr >= 0) tgt = fr;
      else begin
        tgt = m_ptr; stl = 1; m_ptr = (m_ptr + 1) % NV;
      end
      m_act[tgt] = 1; m_note[tgt] = note; m_oct[tgt] = oct;
      m_vnote = note; m_voct = oct; pulse = 1;
    end else if (hit >= 0) begin
      tgt = hit; m_act[hit] = 0;
    end
  endtask

  // Sends one event, checks every cycle of its life, returns what the commit cycle showed.
  task automatic send_event(input string tag, input bit on, input logic [3:0] note,
                            input logic [2:0] oct, output logic [NV-1:0] obs_ld,
                            output logic obs_steal);
    bit valid_ev, pulse, stl;
    int tgt, waited;
    logic [NV-1:0] exp_ld;
    obs_ld = 'x; obs_steal = 1'bx;
    @(negedge clk);
    bus.ev_valid = 1'b1; bus.ev_on = on; bus.ev_note = note; bus.ev_octave = oct;
    waited = 0;
    while (bus.ev_ready !== 1'b1 && waited < 8) begin
      @(negedge clk); waited++;
    end
    tests++;
    if (bus.ev_ready !== 1'b1) begin
      failed++;
      $display("FAIL %s ready_timeout: ev_ready got %b want 1", tag, bus.ev_ready);
      bus.ev_valid = 1'b0;
      return;
    end
    model_apply(on, note, oct, valid_ev, pulse, stl, tgt);
    exp_ld = pulse ? (NV'(1) << tgt) : '0;
    @(posedge clk); #1;
    bus.ev_valid = 1'b0; bus.ev_on = 1'($urandom);
    bus.ev_note = 4'($urandom); bus.ev_octave = 3'($urandom);

    @(negedge clk);
    if (!valid_ev) begin
      tests++;
      if (bus.ev_ready !== 1'b1 || bus.voice_ld !== '0 || bus.voice_active !== m_mask()) begin
        failed++;
        $display("FAIL %s dropped: ready=%b ld=%b active=%b want ready=1 ld=0 active=%b",
                 tag, bus.ev_ready, bus.voice_ld, bus.voice_active, m_mask());
      end
      obs_ld = bus.voice_ld; obs_steal = bus.steal;
      return;
    end
    tests++;
    if (bus.ev_ready !== 1'b0 || bus.voice_ld !== '0) begin
      failed++;
      $display("FAIL %s search: ready=%b ld=%b want ready=0 ld=0", tag, bus.ev_ready, bus.voice_ld);
    end

    @(negedge clk);
    obs_ld = bus.voice_ld; obs_steal = bus.steal;
    tests++;
    if (bus.voice_ld !== exp_ld || bus.steal !== stl) begin
      failed++;
      $display("FAIL %s commit_pulse: ld=%b steal=%b want ld=%b steal=%b",
               tag, bus.voice_ld, bus.steal, exp_ld, stl);
    end
    tests++;
    if (bus.voice_active !== m_mask()) begin
      failed++;
      $display("FAIL %s commit_active: got %b want %b", tag, bus.voice_active, m_mask());
    end
    tests++;
    if (bus.voice_note !== m_vnote || bus.voice_octave !== m_voct) begin
      failed++;
      $display("FAIL %s commit_load: note/oct got %0d/%0d want %0d/%0d",
               tag, bus.voice_note, bus.voice_octave, m_vnote, m_voct);
    end

    @(negedge clk);
    tests++;
    if (bus.ev_ready !== 1'b1 || bus.voice_ld !== '0 || bus.steal !== 1'b0) begin
      failed++;
      $display("FAIL %s back_idle: ready=%b ld=%b steal=%b want 1/0/0",
               tag, bus.ev_ready, bus.voice_ld, bus.steal);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.voice_active !== '0 || bus.voice_ld !== '0 || bus.steal !== 1'b0) begin
      failed++;
      $display("FAIL reset_hold: active=%b ld=%b steal=%b want 0/0/0",
               bus.voice_active, bus.voice_ld, bus.steal);
    end
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    tests++;
    if (bus.ev_ready !== 1'b1 || bus.voice_note !== 4'd0 || bus.voice_octave !== 3'd0) begin
      failed++;
      $display("FAIL reset_release: ready=%b note=%0d oct=%0d want 1/0/0",
               bus.ev_ready, bus.voice_note, bus.voice_octave);
    end
  endtask

  task automatic test_alloc();
    logic [NV-1:0] ld; logic st;
    send_event("alloc0", 1'b1, 4'd9, 3'd4, ld, st);
    tests++;
    if (ld !== 4'b0001) begin
      failed++; $display("FAIL alloc_first: ld=%b want 0001", ld);
    end
    send_event("alloc1", 1'b1, 4'd0, 3'd5, ld, st);
    tests++;
    if (ld !== 4'b0010 || bus.voice_active !== 4'b0011) begin
      failed++; $display("FAIL alloc_second: ld=%b active=%b want 0010/0011", ld, bus.voice_active);
    end
  endtask

  task automatic test_steal();
    logic [NV-1:0] ld; logic st;
    send_event("fill2", 1'b1, 4'd1, 3'd1, ld, st);
    send_event("fill3", 1'b1, 4'd2, 3'd2, ld, st);
    tests++;
    if (bus.voice_active !== 4'b1111) begin
      failed++; $display("FAIL full: active=%b want 1111", bus.voice_active);
    end
    send_event("steal5", 1'b1, 4'd3, 3'd3, ld, st);
    tests++;
    if (ld !== 4'b0001 || st !== 1'b1) begin
      failed++; $display("FAIL steal_first: ld=%b steal=%b want 0001/1", ld, st);
    end
    send_event("steal6", 1'b1, 4'd4, 3'd3, ld, st);
    tests++;
    if (ld !== 4'b0010 || st !== 1'b1) begin
      failed++; $display("FAIL steal_second: ld=%b steal=%b want 0010/1", ld, st);
    end
    for (int k = 0; k < 4; k++) send_event("steal_wrap", 1'b1, 4'(5 + k), 3'd3, ld, st);
    send_event("steal_after_wrap", 1'b1, 4'd9, 3'd6, ld, st);
    tests++;
    if (ld !== 4'b0100 || st !== 1'b1) begin
      failed++; $display("FAIL steal_wrap: ld=%b steal=%b want 0100/1", ld, st);
    end
  endtask

  task automatic test_release();
    logic [NV-1:0] ld; logic st;
    send_event("release_v2", 1'b0, m_note[2], m_oct[2], ld, st);
    tests++;
    if (bus.voice_active !== 4'b1011 || ld !== '0) begin
      failed++; $display("FAIL release: active=%b ld=%b want 1011/0000", bus.voice_active, ld);
    end
    send_event("reuse_v2", 1'b1, 4'd10, 3'd2, ld, st);
    tests++;
    if (ld !== 4'b0100 || st !== 1'b0) begin
      failed++; $display("FAIL reuse: ld=%b steal=%b want 0100/0", ld, st);
    end
  endtask

  task automatic test_edge_cases();
    logic [NV-1:0] ld; logic st;
    send_event("retrigger", 1'b1, 4'd10, 3'd2, ld, st);
    tests++;
    if (ld !== 4'b0100 || bus.voice_active !== 4'b1111) begin
      failed++; $display("FAIL retrigger: ld=%b active=%b want 0100/1111", ld, bus.voice_active);
    end
    send_event("off_unheld", 1'b0, 4'd11, 3'd6, ld, st);
    send_event("bad_note", 1'b1, 4'd13, 3'd4, ld, st);
    send_event("bad_octave", 1'b1, 4'd3, 3'd7, ld, st);
  endtask

  task automatic test_random();
    logic [NV-1:0] ld; logic st;
    logic [3:0] n; logic [2:0] o;
    for (int k = 0; k < 60; k++) begin
      n = 4'($urandom_range(0, 13));
      o = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(3, 4));
      send_event("random", ($urandom_range(0, 2) != 0), n, o, ld, st);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
  endtask

  task automatic test_reset_midop();
    if (m_mask() == '0) begin
      logic [NV-1:0] ld; logic st;
      send_event("pre_midop", 1'b1, 4'd5, 3'd5, ld, st);
    end
    @(negedge clk);
    bus.ev_valid = 1'b1; bus.ev_on = 1'b1; bus.ev_note = 4'd7; bus.ev_octave = 3'd2;
    @(posedge clk); #1;
    bus.ev_valid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (bus.voice_ld !== '0 || bus.voice_active !== '0 || bus.ev_ready !== 1'b1) begin
        failed++;
        $display("FAIL reset_midop: ld=%b active=%b ready=%b want 0000/0000/1",
                 bus.voice_ld, bus.voice_active, bus.ev_ready);
      end
    end
  endtask

  initial begin
    bus.ev_valid = 1'b0; bus.ev_on = 1'b0; bus.ev_note = '0; bus.ev_octave = '0;
    test_reset();
    test_alloc();
    test_steal();
    test_release();
    test_edge_cases();
    test_random();
    test_reset_midop();
    test_alloc();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
